// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
package apb_bridge_pkg;

  localparam int NUM_SLV = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAPT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_e;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY carry no data.
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// AHB-Lite slave side and APB master side of the bridge in one bundle.
// The bridge connects through "slave"; the surrounding bus fabric
// (AHB master plus muxed APB peripherals) connects through "master".
interface ahb2apb_bridge_if #(
  parameter int PADDR_W = 16
);

  logic               HSEL;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic               HWRITE;
  logic [31:0]        HWDATA;
  logic               HREADY;
  logic               HREADYOUT;
  logic               HRESP;
  logic [31:0]        HRDATA;

  logic [PADDR_W-1:0] PADDR;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [15:0]        PSEL;
  logic               PENABLE;
  logic [31:0]        PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    input  PRDATA, PREADY, PSLVERR,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PWRITE, PWDATA, PSEL, PENABLE
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
    output PRDATA, PREADY, PSLVERR,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PWRITE, PWDATA, PSEL, PENABLE
  );

endinterface

// File: rtl/apb_sel_dec.sv
// Slave index to one-hot PSEL decode with per-slot enable masking.
// An unmapped slot never produces a select; the flag lets the FSM
// answer with an AHB error instead of starting an APB cycle.
module apb_sel_dec
  import apb_bridge_pkg::*;
#(
  parameter logic [NUM_SLV-1:0] SLV_EN = '1
) (
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_SLV-1:0] psel_onehot,
  output logic               unmapped
);

  // One-hot select, gated by the enable input and the slot mask.
  always_comb begin
    psel_onehot = '0;
    unmapped    = ~SLV_EN[idx];
    if (en && SLV_EN[idx]) begin
      psel_onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge for up to 16 peripherals.
// One transfer at a time; all bus outputs come straight from flops.
//
// state  | meaning
// IDLE   | ready, OKAY; samples the next address phase
// CAPT   | AHB data phase, captures HWDATA on writes
// SETUP  | APB setup phase (PSEL set, PENABLE low)
// ACCESS | APB access phase, held until PREADY
// ERR1   | first error cycle (HRESP=1, HREADYOUT=0)
// ERR2   | second error cycle (HRESP=1, HREADYOUT=1)
module ahb2apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int                 PADDR_W = 16,
  parameter int                 DEC_LSB = 16,
  parameter logic [NUM_SLV-1:0] SLV_EN  = 16'hFFFF
) (
  input logic                PCLK,
  input logic                PRST,
  ahb2apb_bridge_if.slave    bus
);

  state_e               state, state_n;
  logic [PADDR_W-1:0]   paddr_q, paddr_n;
  logic                 pwrite_q, pwrite_n;
  logic [31:0]          pwdata_q, pwdata_n;
  logic [NUM_SLV-1:0]   psel_q, psel_n;
  logic                 penable_q, penable_n;
  logic                 hready_q, hready_n;
  logic                 hresp_q, hresp_n;
  logic [31:0]          hrdata_q, hrdata_n;
  logic [IDX_W-1:0]     idx_q, idx_n;

  logic [IDX_W-1:0]     haddr_idx;
  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_en;
  logic [NUM_SLV-1:0]   dec_onehot;
  logic                 dec_unmapped;
  logic                 xfer_valid;
  logic                 unused_haddr;

  assign haddr_idx    = bus.HADDR[DEC_LSB+IDX_W-1:DEC_LSB];
  assign xfer_valid   = bus.HSEL & bus.HREADY & trans_active(bus.HTRANS);
  // IDLE checks the incoming address for a mapped slot; CAPT builds PSEL
  // from the latched index.
  assign dec_idx      = (state == ST_IDLE) ? haddr_idx : idx_q;
  assign dec_en       = (state == ST_CAPT);
  assign unused_haddr = ^bus.HADDR;

  apb_sel_dec #(.SLV_EN(SLV_EN)) u_sel_dec (
    .idx         (dec_idx),
    .en          (dec_en),
    .psel_onehot (dec_onehot),
    .unmapped    (dec_unmapped)
  );

  // State and registered bus outputs; reset abandons any transfer.
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      state     <= ST_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      hready_q  <= 1'b1;
      hresp_q   <= HRESP_OKAY;
      hrdata_q  <= '0;
      idx_q     <= '0;
    end else begin
      state     <= state_n;
      paddr_q   <= paddr_n;
      pwrite_q  <= pwrite_n;
      pwdata_q  <= pwdata_n;
      psel_q    <= psel_n;
      penable_q <= penable_n;
      hready_q  <= hready_n;
      hresp_q   <= hresp_n;
      hrdata_q  <= hrdata_n;
      idx_q     <= idx_n;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n   = state;
    paddr_n   = paddr_q;
    pwrite_n  = pwrite_q;
    pwdata_n  = pwdata_q;
    psel_n    = psel_q;
    penable_n = penable_q;
    hrdata_n  = hrdata_q;
    idx_n     = idx_q;

    case (state)
      ST_IDLE: begin
        if (xfer_valid) begin
          paddr_n  = bus.HADDR[PADDR_W-1:0];
          pwrite_n = bus.HWRITE;
          idx_n    = haddr_idx;
          state_n  = dec_unmapped ? ST_ERR1 : ST_CAPT;
        end
      end
      ST_CAPT: begin
        if (pwrite_q) begin
          pwdata_n = bus.HWDATA;
        end
        psel_n  = dec_onehot;
        state_n = ST_SETUP;
      end
      ST_SETUP: begin
        penable_n = 1'b1;
        state_n   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          psel_n    = '0;
          penable_n = 1'b0;
          if (!pwrite_q && !bus.PSLVERR) begin
            hrdata_n = bus.PRDATA;
          end
          state_n = bus.PSLVERR ? ST_ERR1 : ST_IDLE;
        end
      end
      ST_ERR1: state_n = ST_ERR2;
      // Whatever the master presents here is its cancelled follow-up.
      ST_ERR2: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    hready_n = (state_n == ST_IDLE) || (state_n == ST_ERR2);
    hresp_n  = (state_n == ST_ERR1) || (state_n == ST_ERR2);
  end

  assign bus.HREADYOUT = hready_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;

endmodule

// File: doc/ahb2apb_bridge.md
Name: ahb2apb_bridge

Overview:
- AHB-Lite slave to APB master bridge; drives the request side of the APB bus (PADDR/PWRITE/PWDATA/PSEL[15:0]/PENABLE) for up to 16 peripherals.
- Returns PRDATA, PREADY and PSLVERR to AHB. PRDATA, PREADY and PSLVERR arrive already multiplexed by the APB read-data mux driven from this block's PSEL.
- Single clock domain: AHB and APB share PCLK.

Parameters:
- PADDR_W, 16: width of PADDR, taken from HADDR[PADDR_W-1:0].
- DEC_LSB, 16: lowest HADDR bit of the 4-bit slave index (HADDR[DEC_LSB+3:DEC_LSB]).
- SLV_EN, 16'hFFFF: per-slave enable mask; bit i=0 means slot i is unmapped.

Ports:
- PCLK  in  1  clock
- PRST  in  1  reset, asynchronous, active-high
- HSEL  in  1  bridge selected
- HADDR  in  32  AHB address
- HTRANS  in  2  AHB transfer type
- HWRITE  in  1  AHB direction
- HWDATA  in  32  AHB write data (valid in data phase)
- HREADY  in  1  AHB bus ready (address-phase qualifier)
- HREADYOUT  out  1  bridge ready
- HRESP  out  1  0=OKAY, 1=ERROR
- HRDATA  out  32  read data
- PADDR  out  PADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSEL  out  16  one-hot slave select
- PENABLE  out  1  APB access phase
- PRDATA  in  32  muxed read data
- PREADY  in  1  muxed slave ready
- PSLVERR  in  1  muxed slave error

Behaviour:
- Reset (async, any state): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PADDR=0, PWRITE=0, PWDATA=0, PSEL=0, PENABLE=0. An in-flight transfer is abandoned with no completion.
- Valid transfer: HSEL & HREADY & HTRANS[1], i.e. NONSEQ or SEQ. On IDLE or BUSY while selected, respond OKAY with zero wait states and no APB activity.
- FSM states: IDLE, CAPT, SETUP, ACCESS, ERR1, ERR2. Registered outputs.
- IDLE: HREADYOUT=1, HRESP=0. On a valid transfer:
  - Latch HADDR into PADDR, HWRITE into PWRITE, and the index idx.
  - If SLV_EN[idx]=0, go to ERR1 with no APB cycle.
  - Otherwise go to CAPT.
- CAPT: HREADYOUT=0. If PWRITE, PWDATA<=HWDATA. Next state SETUP, with PSEL<=onehot(idx) set at the transition.
- SETUP: PSEL set, PENABLE=0, HREADYOUT=0. Next state ACCESS, with PENABLE<=1.
- ACCESS: PSEL and PENABLE held. All APB outputs stay stable while PREADY=0; there is no timeout. On PREADY=1:
  - PSEL<=0 and PENABLE<=0.
  - If the transfer is a read and PSLVERR=0, HRDATA<=PRDATA. HRDATA holds its value on writes and on errors.
  - If PSLVERR=1, go to ERR1; otherwise go to IDLE.
- ERR1: HRESP=1, HREADYOUT=0. ERR2: HRESP=1, HREADYOUT=1. ERR2 always goes to IDLE. This is the two-cycle AHB error response. A transfer presented during ERR2 is ignored (the master cancels it).
- Back-to-back transfers: the completion cycle is the first IDLE cycle, and it may sample the next pipelined address. No bubble is added beyond the FSM.
- Latency with PREADY=1 in the first ACCESS cycle: 3 wait states.
  - Address phase at cycle N; CAPT N+1, SETUP N+2, ACCESS N+3.
  - HREADYOUT=1 with valid HRDATA at N+4.
  - Each PREADY=0 cycle adds one wait state.
- PSEL is never multi-hot and is zero outside SETUP/ACCESS. PENABLE=1 only in ACCESS.
- HSIZE and HPROT are not used: all accesses are 32-bit.

Decomposition:
- Package apb_bridge_pkg: FSM state encodings, HTRANS codes (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11), NUM_SLV=16, HRESP codes.
- Sub-module apb_sel_dec: 4-bit index plus enable to 16-bit one-hot PSEL, with an output flag for unmapped slots (SLV_EN masking).

Test Plan:
- Write 0x0003_0010 with HWDATA 0xDEADBEEF, PREADY=1 -> PSEL=16'h0008, PADDR=0x0010, PWRITE=1, PWDATA=0xDEADBEEF in SETUP and ACCESS; HREADYOUT low 3 cycles; HRESP=0.
- Read 0x000F_0004 with PRDATA=0x12345678 and PREADY low 2 ACCESS cycles -> PSEL=16'h8000, 5 wait states, HRDATA=0x12345678 when HREADYOUT rises.
- Read with PSLVERR=1 at PREADY -> HRESP=1 for 2 cycles (HREADYOUT 0 then 1); HRDATA unchanged.
- SLV_EN=16'hFFFE, access to 0x0000_0000 -> PSEL stays 0; ERROR response 1 cycle after the address phase.
- Back-to-back read then write, plus HTRANS=BUSY or IDLE cycles -> second transfer sampled in the completion cycle; BUSY and IDLE get OKAY with no PSEL.
- PRST pulsed during ACCESS -> all outputs return to reset values asynchronously; the next transfer completes normally.
